// File: rtl/dc_ac_sweep_stim.sv
// Multi-channel DC+AC stimulus source: per-channel NCO, parabolic sine, gain, offset, stepped sweep.
// Define STIM_SAT_FLAG_EN to add the sticky per-channel sat_flag output.
module dc_ac_sweep_stim #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned STEP_W  = 10,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [2:0]           cfg_addr,
  input  logic [31:0]          cfg_data,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
`ifdef STIM_SAT_FLAG_EN
  output logic [NCH-1:0]       sat_flag,
`endif
  output logic [NCH*OUT_W-1:0] sample
);

  typedef enum logic [0:0] {StIdle = 1'b0, StRun = 1'b1} state_e;

  state_e state_q, state_d;

  // Programmed configuration
  logic [PHASE_W-1:0] ftw_start_q [NCH];
  logic [PHASE_W-1:0] ftw_start_d [NCH];
  logic [PHASE_W-1:0] ftw_step_q  [NCH];
  logic [PHASE_W-1:0] ftw_step_d  [NCH];
  logic [15:0]        amp_q       [NCH];
  logic [15:0]        amp_d       [NCH];
  logic [15:0]        dc_q        [NCH];
  logic [15:0]        dc_d        [NCH];
  logic [15:0]        phoff_q     [NCH];
  logic [15:0]        phoff_d     [NCH];
  logic [STEP_W-1:0]  nsteps_q, nsteps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [15:0]        div_q, div_d;

  // Run state
  logic [PHASE_W-1:0] ftw_q      [NCH];
  logic [PHASE_W-1:0] ftw_d      [NCH];
  logic [PHASE_W-1:0] phase_q    [NCH];
  logic [PHASE_W-1:0] phase_d    [NCH];
  logic [15:0]        amp_run_q  [NCH];
  logic [15:0]        amp_run_d  [NCH];
  logic [15:0]        dc_run_q   [NCH];
  logic [15:0]        dc_run_d   [NCH];
  logic [15:0]        tick_cnt_q, tick_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;

  // Output pipeline
  logic signed [15:0]   wave_q [NCH];
  logic signed [15:0]   wave_d [NCH];
  logic                 v1_q, v1_d;
  logic                 last1_q, last1_d;
  logic [NCH*OUT_W-1:0] sample_q, sample_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 done_q, done_d;
  logic [NCH-1:0]       sat_hit;

  logic run, cfg_we, ch_ok, start_acc, flush, tick, dwell_hit, last_tick;

  assign run       = (state_q == StRun);
  assign cfg_ready = (state_q == StIdle);
  assign cfg_we    = cfg_valid && cfg_ready;
  assign ch_ok     = (32'(cfg_ch) < NCH);
  assign start_acc = !run && start && !stop;
  assign flush     = run && stop;
  assign tick      = run && !stop && (tick_cnt_q == '0);
  assign dwell_hit = (dwell_cnt_q == dwell_q);
  assign last_tick = tick && dwell_hit && (nsteps_q != '0) && (step_cnt_q == nsteps_q);

  assign busy         = run;
  assign done         = done_q;
  assign sample_valid = sample_valid_q;
  assign sample       = sample_q;

  logic unused_cfg_data;
  assign unused_cfg_data = ^cfg_data;

  // Parabolic half-wave per sign half: y = x*(32768-x)/8192, capped at full scale.
  function automatic logic signed [15:0] sine_approx(input logic [15:0] p);
    logic [30:0] prod;
    logic [17:0] y;
    logic [15:0] ym;
    prod = 31'(p[14:0]) * (31'd32768 - 31'(p[14:0]));
    y    = 18'(prod >> 13);
    ym   = (y > 18'd32767) ? 16'd32767 : y[15:0];
    return p[15] ? -$signed(ym) : $signed(ym);
  endfunction

  always_comb begin
    ftw_start_d = ftw_start_q;
    ftw_step_d  = ftw_step_q;
    amp_d       = amp_q;
    dc_d        = dc_q;
    phoff_d     = phoff_q;
    nsteps_d    = nsteps_q;
    dwell_d     = dwell_q;
    div_d       = div_q;
    if (cfg_we) begin
      unique case (cfg_addr)
        3'd0: if (ch_ok) ftw_start_d[cfg_ch] = cfg_data[PHASE_W-1:0];
        3'd1: if (ch_ok) ftw_step_d[cfg_ch] = cfg_data[PHASE_W-1:0];
        3'd2: if (ch_ok) amp_d[cfg_ch] = cfg_data[15:0];
        3'd3: if (ch_ok) dc_d[cfg_ch] = cfg_data[15:0];
        3'd4: if (ch_ok) phoff_d[cfg_ch] = cfg_data[15:0];
        3'd5: nsteps_d = cfg_data[STEP_W-1:0];
        3'd6: dwell_d = cfg_data[DWELL_W-1:0];
        3'd7: div_d = cfg_data[15:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    phase_d     = phase_q;
    amp_run_d   = amp_run_q;
    dc_run_d    = dc_run_q;
    tick_cnt_d  = tick_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    step_cnt_d  = step_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d     = StRun;
          tick_cnt_d  = '0;
          dwell_cnt_d = '0;
          step_cnt_d  = '0;
          for (int k = 0; k < int'(NCH); k++) begin
            ftw_d[k]     = ftw_start_q[k];
            phase_d[k]   = PHASE_W'(phoff_q[k]) << (PHASE_W - 16);
            amp_run_d[k] = amp_q[k];
            dc_run_d[k]  = dc_q[k];
          end
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          tick_cnt_d = (tick_cnt_q == div_q) ? '0 : tick_cnt_q + 16'd1;
          if (tick) begin
            for (int k = 0; k < int'(NCH); k++) begin
              phase_d[k] = phase_q[k] + ftw_q[k];
            end
            if (!dwell_hit) begin
              dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end else begin
              dwell_cnt_d = '0;
              if (last_tick) begin
                state_d = StIdle;
              end else if (nsteps_q != '0) begin
                for (int k = 0; k < int'(NCH); k++) begin
                  ftw_d[k] = ftw_q[k] + ftw_step_q[k];
                end
                step_cnt_d = step_cnt_q + STEP_W'(1);
              end
            end
          end
        end
      end
    endcase
  end

  // Stage 1 captures the waveform on a tick; stage 2 applies gain, offset and saturation.
  always_comb begin
    logic signed [32:0] prod;
    logic signed [32:0] sum;
    logic signed [15:0] clamped;
    logic               clip;
    wave_d         = wave_q;
    sample_d       = sample_q;
    sat_hit        = '0;
    v1_d           = tick;
    last1_d        = last_tick;
    sample_valid_d = v1_q && !flush;
    done_d         = v1_q && last1_q && !flush;
    for (int k = 0; k < int'(NCH); k++) begin
      if (tick) wave_d[k] = sine_approx(phase_q[k][PHASE_W-1 -: 16]);
      prod = 33'($signed({1'b0, amp_run_q[k]})) * 33'(wave_q[k]);
      sum  = 33'($signed(dc_run_q[k])) + (prod >>> 15);
      clip = 1'b1;
      if (sum > 33'sd32767) begin
        clamped = 16'sh7fff;
      end else if (sum < -33'sd32768) begin
        clamped = 16'sh8000;
      end else begin
        clamped = sum[15:0];
        clip    = 1'b0;
      end
      if (v1_q && !flush) begin
        sample_d[k*OUT_W +: OUT_W] = OUT_W'(clamped);
        sat_hit[k]                 = clip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NCH); k++) begin
        ftw_start_q[k] <= '0;
        ftw_step_q[k]  <= '0;
        amp_q[k]       <= '0;
        dc_q[k]        <= '0;
        phoff_q[k]     <= '0;
        ftw_q[k]       <= '0;
        phase_q[k]     <= '0;
        amp_run_q[k]   <= '0;
        dc_run_q[k]    <= '0;
        wave_q[k]      <= '0;
      end
      nsteps_q       <= '0;
      dwell_q        <= '0;
      div_q          <= '0;
      state_q        <= StIdle;
      tick_cnt_q     <= '0;
      dwell_cnt_q    <= '0;
      step_cnt_q     <= '0;
      v1_q           <= 1'b0;
      last1_q        <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      ftw_start_q    <= ftw_start_d;
      ftw_step_q     <= ftw_step_d;
      amp_q          <= amp_d;
      dc_q           <= dc_d;
      phoff_q        <= phoff_d;
      ftw_q          <= ftw_d;
      phase_q        <= phase_d;
      amp_run_q      <= amp_run_d;
      dc_run_q       <= dc_run_d;
      wave_q         <= wave_d;
      nsteps_q       <= nsteps_d;
      dwell_q        <= dwell_d;
      div_q          <= div_d;
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      dwell_cnt_q    <= dwell_cnt_d;
      step_cnt_q     <= step_cnt_d;
      v1_q           <= v1_d;
      last1_q        <= last1_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
    end
  end

`ifdef STIM_SAT_FLAG_EN
  logic [NCH-1:0] sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = sat_flag_q | sat_hit;
    if (start_acc) sat_flag_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag_q <= '0;
    else        sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = ^sat_hit;
`endif

endmodule

// File: tb/tb_dc_ac_sweep_stim.sv
// Scoreboard bench for dc_ac_sweep_stim: directed DC, tone, saturation, sweep, stop and reset cases.
module tb_dc_ac_sweep_stim;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [0:0]  cfg_ch = '0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, sample_valid;
  logic [31:0] sample;
`ifdef STIM_SAT_FLAG_EN
  logic [1:0]  sat_flag;
`endif

  dc_ac_sweep_stim #(
    .NCH(2), .PHASE_W(24), .OUT_W(16), .DWELL_W(16), .STEP_W(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .done         (done),
    .sample_valid (sample_valid),
`ifdef STIM_SAT_FLAG_EN
    .sat_flag     (sat_flag),
`endif
    .sample       (sample)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] smp;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [15:0] c1, input logic [15:0] c0, input logic dn);
    exp_t e;
    e.smp = {c1, c0};
    e.dn  = dn;
    exp_q.push_back(e);
  endfunction

  // Expected sweep from FTW_START=2^22, FTW_STEP=2^21, DWELL=3, NSTEPS=2; ch1 fixed at -5.
  function automatic void push_sweep();
    logic [15:0] s [12];
    s = '{16'h0000, 16'h7fff, 16'h0000, 16'h8001, 16'h0000, 16'h6000,
          16'h8001, 16'h6000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 12; i++) push(16'hfffb, s[i], i == 11);
  endfunction

  function automatic void push_tone(input int n);
    logic [15:0] t [4];
    t = '{16'h0000, 16'h7fff, 16'h0000, 16'h8001};
    for (int i = 0; i < n; i++) push(16'hfffb, t[i % 4], 1'b0);
  endfunction

  // Monitor: every sample_valid pops one expected entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sample_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {63'd0, sample_valid}, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sample", 64'(sample), 64'(e.smp));
            check("done", {63'd0, done}, {63'd0, e.dn});
          end
        end else if (done) begin
          check("done_without_valid", {63'd0, done}, 64'd0);
        end
      end
    end
  end

  task automatic wr(input int ch, input int addr, input logic [31:0] d);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_addr  = 3'(addr);
    cfg_data  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_size(input string name, input int lim, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > lim && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, {63'd0, exp_q.size() > lim}, 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_valid"}, {63'd0, sample_valid}, 64'd0);
    check({tag, "_cfg_ready"}, {63'd0, cfg_ready}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sample", 64'(sample), 64'd0);
    rst_n = 1'b1;

    // DC only
    wr(0, 3, 32'd1000);
    for (int i = 0; i < 5; i++) push(16'h0000, 16'd1000, 1'b0);
    do_start();
    @(posedge clk);
    #1;
    check("dc_lat1_valid", {63'd0, sample_valid}, 64'd0);
    check("run_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("dc_lat2_valid", {63'd0, sample_valid}, 64'd1);
    check("dc_busy", {63'd0, busy}, 64'd1);
    wait_size("dc_drain", 0, 50);
    do_stop();
    check_idle_outputs("dc_stop");
    check("dc_hold", 64'(sample), 64'h0000_03e8);

    // Tone, with a config write attempted mid-run that must be dropped
    wr(0, 0, 32'h0040_0000);
    wr(0, 2, 32'd32768);
    wr(0, 3, 32'd0);
    wr(1, 3, 32'h0000_fffb);
    push_tone(8);
    do_start();
    @(negedge clk);
    check("hs_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    cfg_valid = 1'b1;
    cfg_ch    = 1'b0;
    cfg_addr  = 3'd2;
    cfg_data  = 32'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_size("tone_drain", 0, 50);
    do_stop();
`ifdef STIM_SAT_FLAG_EN
    check("tone_sat_flag", 64'(sat_flag), 64'd0);
`endif

    // Saturation: AMP must still be 32768
    wr(0, 3, 32'd30000);
    push(16'hfffb, 16'd30000, 1'b0);
    push(16'hfffb, 16'h7fff, 1'b0);
    push(16'hfffb, 16'd30000, 1'b0);
    push(16'hfffb, 16'hf531, 1'b0);
    do_start();
    wait_size("sat_drain", 0, 50);
    do_stop();
`ifdef STIM_SAT_FLAG_EN
    check("sat_flag", 64'(sat_flag), 64'd1);
`endif

    // Sweep to completion
    wr(0, 3, 32'd0);
    wr(0, 1, 32'h0020_0000);
    wr(0, 5, 32'd2);
    wr(0, 6, 32'd3);
    wr(0, 7, 32'd1);
    push_sweep();
    do_start();
    wait_size("sweep_drain", 0, 100);
    check("sweep_busy_end", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("sweep_done_pulse", {63'd0, done}, 64'd0);

    // stop+start together mid-sweep
    push_sweep();
    do_start();
    wait_size("ss_progress", 9, 50);
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("ss_busy", {63'd0, busy}, 64'd0);
    check("ss_valid", {63'd0, sample_valid}, 64'd0);
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    exp_q.delete();
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    check("ss_no_done", 64'(seen_done), 64'd0);

    // Asynchronous reset mid-sweep
    push_sweep();
    do_start();
    wait_size("rst_progress", 9, 50);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_sample", 64'(sample), 64'd0);
`ifdef STIM_SAT_FLAG_EN
    check("mid_rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Tone again after reset (registers were cleared)
    wr(0, 0, 32'h0040_0000);
    wr(0, 2, 32'd32768);
    wr(1, 3, 32'h0000_fffb);
    push_tone(4);
    do_start();
    wait_size("retone_drain", 0, 50);
    do_stop();
    check_idle_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
